usrt_tx: RTL and testbench

Serial transmit engine of the USRT. It consumes the configuration byte held by the status register (baud select, parity enable, parity sense) and a parallel data byte from the bus side. It serialises the byte onto a data line together with a generated synchronous bit clock. It is the outbound counterpart of the status register, reading what that register stores.

---
 rtl/usrt_tx.sv | 132 +++++++++++++
 tb/tb_usrt_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_tx.sv
// USRT serial transmit engine: start bit, LSB-first data, optional parity, stop bit(s), with a synchronous bit clock.
// Optional build macro USRT_TX_TWO_STOP_EN selects two stop bits instead of one.
module usrt_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_BASE   = 4
) (
  input  logic                  i_Pclk,
  input  logic                  i_Reset,
  input  logic [7:0]            i_Status,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Sclk,
  output logic                  o_Sdata
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [5:0]            div_cnt, div_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic                  stop2, stop2_n;
  logic                  done, done_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en, par_odd;
  logic [1:0]            sel;
  logic [6:0]            period;
  logic                  bit_end, sclk_hi, accept;
  logic                  unused_status;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign unused_status = ^i_Status[7:4];
  assign period  = 7'(DIV_BASE) << sel;
  assign bit_end = ({1'b0, div_cnt} == (period - 7'd1));
  assign sclk_hi = ({1'b0, div_cnt} >= (period >> 1));
  assign accept  = i_Valid && (state == IDLE);

  // Frame configuration and payload are frozen at acceptance
  always_ff @(posedge i_Pclk) begin
    if (accept) begin
      data_q  <= i_Data;
      par_en  <= i_Status[0];
      par_odd <= i_Status[1];
      sel     <= i_Status[3:2];
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Reset) begin
      state   <= IDLE;
      div_cnt <= 6'd0;
      bit_cnt <= '0;
      stop2   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      stop2   <= stop2_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    stop2_n = stop2;
    done_n  = 1'b0;
    if (state != IDLE) div_n = bit_end ? 6'd0 : div_cnt + 6'd1;
    case (state)
      IDLE: begin
        if (i_Valid) begin
          state_n = START;
          div_n   = 6'd0;
          bit_n   = '0;
          stop2_n = 1'b0;
        end
      end
      START:  if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = par_en ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (bit_end) begin
`ifdef USRT_TX_TWO_STOP_EN
          if (!stop2) begin
            stop2_n = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
`else
          state_n = IDLE;
          done_n  = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line is driven straight from state so data moves only while sclk is low
  always_comb begin
    o_Sdata = 1'b1;
    o_Sclk  = 1'b0;
    case (state)
      START:   o_Sdata = 1'b0;
      DATA:    o_Sdata = data_q[bit_cnt];
      PARITY:  o_Sdata = parity_bit(data_q, par_odd);
      default: o_Sdata = 1'b1;
    endcase
    if (state != IDLE) o_Sclk = sclk_hi;
  end

  assign o_Ready = (state == IDLE);
  assign o_Busy  = (state != IDLE);
  assign o_Done  = done;

endmodule

// File: tb/tb_usrt_tx.sv
// Self-checking bench for usrt_tx: a frame-level model predicts the line, clock and handshake every cycle.
module tb_usrt_tx;

`ifdef USRT_TX_TWO_STOP_EN
  localparam bit TWO_STOP = 1'b1;
`else
  localparam bit TWO_STOP = 1'b0;
`endif

  logic       r_Clock = 1'b0;
  logic       i_Reset = 1'b0;
  logic [7:0] i_Status = 8'h00;
  logic [7:0] i_Data = 8'h00;
  logic       i_Valid = 1'b0;
  logic       o_Ready, o_Busy, o_Done, o_Sclk, o_Sdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_bits[$];

  usrt_tx dut (
    .i_Pclk  (r_Clock),
    .i_Reset (i_Reset),
    .i_Status(i_Status),
    .i_Data  (i_Data),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done),
    .o_Sclk  (o_Sclk),
    .o_Sdata (o_Sdata)
  );

  always #5 r_Clock = ~r_Clock;

  // Frame as a list of line bits; bit period from the baud select
  function automatic void model_frame(input logic [7:0] d, input logic [7:0] st,
                                      output int p, output int n);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (st[0]) exp_bits.push_back((^d) ^ st[1]);
    exp_bits.push_back(1'b1);
    if (TWO_STOP) exp_bits.push_back(1'b1);
    p = 4 << st[3:2];
    n = exp_bits.size();
  endfunction

  task automatic accept(input logic [7:0] d, input logic [7:0] st);
    i_Data = d;
    i_Status = st;
    i_Valid = 1'b1;
    @(posedge r_Clock);
    #1;
    i_Valid = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    i_Valid = 1'b1;
    repeat (2) @(posedge r_Clock);
    #1;
    i_Valid = 1'b0;
    i_Reset = 1'b1;
    @(negedge r_Clock);
    n_tests++;
    if ({o_Ready, o_Busy, o_Sclk, o_Sdata, o_Done} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset rdy/busy/sclk/sdata/done got %b exp 10010",
               {o_Ready, o_Busy, o_Sclk, o_Sdata, o_Done});
    end
  endtask

  task automatic test_basic();
    int p, n;
    logic busy_e, sd_e, sc_e;
    model_frame(8'hA5, 8'h00, p, n);
    accept(8'hA5, 8'h00);
    for (int c = 1; c <= n * p + 1; c++) begin
      @(negedge r_Clock);
      busy_e = (c <= n * p);
      sd_e = busy_e ? exp_bits[(c - 1) / p] : 1'b1;
      sc_e = busy_e && (((c - 1) % p) >= p / 2);
      n_tests++;
      if ({o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk} !== {busy_e, !busy_e, !busy_e, sd_e, sc_e}) begin
        n_fail++;
        $display("FAIL basic cycle %0d busy/rdy/done/sd/sc got %b exp %b", c,
                 {o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk}, {busy_e, !busy_e, !busy_e, sd_e, sc_e});
      end
    end
  endtask

  task automatic test_parity();
    int p, n;
    logic busy_e, sd_e, sc_e;
    logic [7:0] st;
    for (int k = 0; k < 2; k++) begin
      st = (k == 0) ? 8'h01 : 8'h03;
      model_frame(8'h07, st, p, n);
      accept(8'h07, st);
      for (int c = 1; c <= n * p + 1; c++) begin
        @(negedge r_Clock);
        busy_e = (c <= n * p);
        sd_e = busy_e ? exp_bits[(c - 1) / p] : 1'b1;
        sc_e = busy_e && (((c - 1) % p) >= p / 2);
        n_tests++;
        if ({o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk} !== {busy_e, !busy_e, !busy_e, sd_e, sc_e}) begin
          n_fail++;
          $display("FAIL parity st=%h cycle %0d got %b exp %b", st, c,
                   {o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk}, {busy_e, !busy_e, !busy_e, sd_e, sc_e});
        end
      end
    end
  endtask

  task automatic test_baud();
    int p, n;
    logic busy_e, sd_e, sc_e;
    model_frame(8'hFF, 8'h0C, p, n);
    accept(8'hFF, 8'h0C);
    for (int c = 1; c <= n * p + 1; c++) begin
      @(negedge r_Clock);
      busy_e = (c <= n * p);
      sd_e = busy_e ? exp_bits[(c - 1) / p] : 1'b1;
      sc_e = busy_e && (((c - 1) % p) >= p / 2);
      n_tests++;
      if ({o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk} !== {busy_e, !busy_e, !busy_e, sd_e, sc_e}) begin
        n_fail++;
        $display("FAIL baud cycle %0d got %b exp %b", c,
                 {o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk}, {busy_e, !busy_e, !busy_e, sd_e, sc_e});
      end
      if (c == 5) begin
        i_Status = 8'h00;
        i_Data = 8'h00;
      end
    end
  endtask

  task automatic test_back_to_back();
    int p, n;
    logic busy_e, sd_e, sc_e;
    logic [7:0] d;
    model_frame(8'h01, 8'h00, p, n);
    i_Data = 8'h01;
    i_Status = 8'h00;
    i_Valid = 1'b1;
    @(posedge r_Clock);
    #1;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h01 : 8'h80;
      if (f == 1) begin
        model_frame(8'h80, 8'h00, p, n);
        @(posedge r_Clock);
        #1;
        i_Valid = 1'b0;
      end
      for (int c = 1; c <= n * p + 1; c++) begin
        @(negedge r_Clock);
        busy_e = (c <= n * p);
        sd_e = busy_e ? exp_bits[(c - 1) / p] : 1'b1;
        sc_e = busy_e && (((c - 1) % p) >= p / 2);
        n_tests++;
        if ({o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk} !== {busy_e, !busy_e, !busy_e, sd_e, sc_e}) begin
          n_fail++;
          $display("FAIL b2b byte %h cycle %0d got %b exp %b", d, c,
                   {o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk}, {busy_e, !busy_e, !busy_e, sd_e, sc_e});
        end
        if (f == 0 && c == 3) i_Data = 8'h80;
      end
    end
  endtask

  task automatic test_abort();
    int p, n;
    logic busy_e, sd_e, sc_e;
    bit seen_done;
    model_frame(8'h55, 8'h00, p, n);
    accept(8'h55, 8'h00);
    for (int c = 1; c <= 19; c++) begin
      @(negedge r_Clock);
      busy_e = 1'b1;
      sd_e = exp_bits[(c - 1) / p];
      sc_e = ((c - 1) % p) >= p / 2;
      n_tests++;
      if ({o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk} !== {busy_e, 1'b0, 1'b0, sd_e, sc_e}) begin
        n_fail++;
        $display("FAIL abort_pre cycle %0d got %b exp %b", c,
                 {o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk}, {busy_e, 1'b0, 1'b0, sd_e, sc_e});
      end
    end
    @(posedge r_Clock);
    #1;
    i_Reset = 1'b0;
    @(negedge r_Clock);
    @(negedge r_Clock);
    n_tests++;
    if ({o_Sdata, o_Sclk, o_Ready, o_Busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL abort_idle sdata/sclk/rdy/busy got %b exp 1010", {o_Sdata, o_Sclk, o_Ready, o_Busy});
    end
    @(posedge r_Clock);
    #1;
    i_Reset = 1'b1;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge r_Clock);
      if (o_Done) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done !== 1'b0 || o_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_done done_seen/rdy got %b%b exp 01", seen_done, o_Ready);
    end
  endtask

  task automatic test_random();
    int p, n;
    logic busy_e, sd_e, sc_e;
    logic [7:0] d, st;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      st = 8'($urandom);
      model_frame(d, st, p, n);
      repeat ($urandom_range(0, 3)) @(negedge r_Clock);
      accept(d, st);
      for (int c = 1; c <= n * p + 1; c++) begin
        @(negedge r_Clock);
        busy_e = (c <= n * p);
        sd_e = busy_e ? exp_bits[(c - 1) / p] : 1'b1;
        sc_e = busy_e && (((c - 1) % p) >= p / 2);
        n_tests++;
        if ({o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk} !== {busy_e, !busy_e, !busy_e, sd_e, sc_e}) begin
          n_fail++;
          $display("FAIL random d=%h st=%h cycle %0d got %b exp %b", d, st, c,
                   {o_Busy, o_Ready, o_Done, o_Sdata, o_Sclk}, {busy_e, !busy_e, !busy_e, sd_e, sc_e});
        end
        if (c == 2) begin
          i_Data = 8'($urandom);
          i_Status = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_baud();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
